// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions: default data width and an index-width helper
// that never yields a zero-width select.
package cpu_bus_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter producing a one-hot grant and its index.
// CHAN_MUX_RR_ARB_EN selects round-robin from ptr; otherwise fixed lowest-index priority.
module rr_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] gidx
);

    logic [NCH-1:0] cand;

`ifdef CHAN_MUX_RR_ARB_EN
    logic [NCH-1:0] hi_req;

    // Requests at or above ptr take precedence; fall back to the wrapped set.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < NCH; i++) begin
            hi_req[i] = req[i] && (i >= int'(ptr));
        end
        cand = (|hi_req) ? hi_req : req;
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign cand       = req;
`endif

    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        gidx  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && cand[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// Registered N-channel valid/ready selector with a one-entry output register.
// Arbitration mode set by CHAN_MUX_RR_ARB_EN (round-robin) or fixed priority when undefined.
module chan_mux_rr
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = 4,
    parameter int SELW  = clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             take;

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign load     = ~out_valid_q | out_ready;
    assign take     = load & (|grant);
    assign in_ready = grant & {NCH{load & rst_n}};

    // One-hot AND-OR mux keeps in_data off every path except into the register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = |grant;
            if (|grant) begin
                out_data_d = sel_data;
                out_sel_d  = gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

`ifdef CHAN_MUX_RR_ARB_EN
    logic [SELW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (take) ptr_d = (gidx == SELW'(NCH-1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Self-checking bench for chan_mux_rr: directed cases plus randomized traffic
// against a transaction-level model; follows CHAN_MUX_RR_ARB_EN like the DUT.
module tb_chan_mux_rr;

    localparam int W   = 32;
    localparam int NCH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    int checks   = 0;
    int failures = 0;

    // Model: contents of the output slot plus the round-robin start point.
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_sel;
    int         m_ptr;
    logic [NCH-1:0] last_acc;

    always #5 clk = ~clk;

    chan_mux_rr #(.WIDTH(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NCH-1:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
`ifdef CHAN_MUX_RR_ARB_EN
            if (v[(p + k) % NCH]) return (p + k) % NCH;
`else
            if (v[k]) return k;
`endif
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] chan_word(input int c);
        return in_data[c*W +: W];
    endfunction

    // Called just after a negedge with inputs settled: compare, take the edge, update the model.
    task automatic cycle();
        int   g;
        bit   ld;
        logic [NCH-1:0] exp_rdy;
        #1;
        g  = pick(in_valid, m_ptr);
        ld = !m_valid || out_ready;
        exp_rdy = '0;
        if (rst_n && ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready",  in_ready,  exp_rdy);
        chk("out_valid", out_valid, m_valid);
        chk("out_data",  out_data,  m_data);
        chk("out_sel",   out_sel,   m_sel);
        @(posedge clk);
        last_acc = exp_rdy;
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = chan_word(g);
                m_sel   = g;
                m_ptr   = (g + 1) % NCH;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_chan(input int c, input logic [W-1:0] d);
        in_data[c*W +: W] = d;
    endtask

    initial begin
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; last_acc = '0;
        rst_n = 1'b0; out_ready = 1'b1; in_valid = '1;
        for (int i = 0; i < NCH; i++) set_chan(i, W'(32'hC0DE_0000 + i));
        @(negedge clk);

        // Reset hold with every channel requesting.
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        cycle();
        chk("first_grant_sel", out_sel, 0);
        chk("first_grant_valid", out_valid, 1);
        in_valid = '0;
        cycle();

        // Single channel.
        in_valid = 4'b0100;
        set_chan(2, 32'hA5A5_0002);
        cycle();
        chk("single_data", out_data, 32'hA5A5_0002);
        chk("single_sel", out_sel, 2);
        in_valid = '0;
        cycle();
        chk("single_drop", out_valid, 0);

        // Arbitration pattern from a fresh pointer.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) set_chan(i, W'(32'h10 + i));
`ifdef CHAN_MUX_RR_ARB_EN
        in_valid = '1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_sel", out_sel, i % NCH);
            chk("rr_data", out_data, 32'h10 + (i % NCH));
            chk("rr_valid", out_valid, 1);
        end
`else
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fp_sel", out_sel, 1);
            chk("fp_ch3_ready", in_ready[3], 0);
        end
`endif
        in_valid = '0;
        cycle();

        // Backpressure with simultaneous drain and refill on release.
        in_valid = 4'b0001;
        set_chan(0, 32'h11);
        cycle();
        chk("bp_load", out_data, 32'h11);
        out_ready = 1'b0;
        set_chan(0, 32'h22);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_hold_data", out_data, 32'h11);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_refill", out_data, 32'h22);
        chk("bp_refill_valid", out_valid, 1);
        in_valid = '0;
        cycle();

        // Reset while a word is held.
        in_valid = 4'b0001;
        set_chan(0, 32'h33);
        cycle();
        in_valid = '0;
        out_ready = 1'b0;
        cycle();
        chk("mid_held", out_data, 32'h33);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = '1;
        cycle();
        chk("mid_restart_sel", out_sel, 0);

        // Randomized traffic obeying the producer hold rule.
        for (int n = 0; n < 3000; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NCH; i++) begin
                if (!(in_valid[i] && !last_acc[i])) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    set_chan(i, W'($urandom));
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
